// File: rtl/timer_bank_pkg.sv
// Shared types and constants for timer_bank: FSM states, register map, MODE codes, CTRL bit positions.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Word offsets within a channel (byte offsets 0x0/0x4/0x8/0xC)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;

  function automatic logic [31:0] beMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS, IDLE-LOAD-CNT-INT FSM, sticky pending; writes take effect next cycle, never stalls.
// Optional 15-bit prescaler under TIMER_BANK_PRESCALE_EN.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  regSel,
  input  logic [31:0] din,
  input  logic [3:0]  be,
  output logic [31:0] rdData,
  output logic        intReq
);

  state_e           state, nextState;
  logic             en, im, pending;
  logic [1:0]       mode;
  logic [3:0]       ps;
  logic [CNT_W-1:0] preset, count;
  logic [31:0]      wrMask, ctrlWord;
  logic             tick, doLoad, doDec, doInt, doStop;
  logic             ctrlWr, presetWr, statusClr;

  assign ctrlWr    = we && regSel == REG_CTRL && be[0];
  assign presetWr  = we && regSel == REG_PRESET;
  assign statusClr = we && regSel == REG_STATUS && be[0] && din[0];
  assign wrMask    = beMask(be);

`ifdef TIMER_BANK_PRESCALE_EN
  logic [14:0] presc, prescMax;

  assign prescMax = 15'((16'd1 << ps) - 16'd1);
  assign tick     = (presc == prescMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      ps    <= '0;
      presc <= '0;
    end else begin
      if (ctrlWr) ps <= din[CTRL_PS_LO +: 4];
      if (state == ST_LOAD)
        presc <= '0;
      else if (state == ST_CNT && en)
        presc <= tick ? 15'd0 : presc + 15'd1;
    end
  end
`else
  assign ps   = '0;
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (en) nextState = ST_LOAD;
      ST_LOAD: nextState = ST_CNT;
      ST_CNT:  if (en && tick && count <= CNT_W'(1)) nextState = ST_INT;
      ST_INT:  nextState = (mode == MODE_AUTO) ? ST_LOAD : ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    doLoad = (state == ST_LOAD);
    doDec  = (state == ST_CNT) && en && tick && count > CNT_W'(1);
    doInt  = (state == ST_CNT) && en && tick && count <= CNT_W'(1);
    doStop = (state == ST_INT) && mode != MODE_AUTO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      mode    <= MODE_ONESHOT;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (ctrlWr) begin
        en   <= din[CTRL_EN];
        mode <= din[CTRL_MODE_LO +: 2];
        im   <= din[CTRL_IM];
      end
      // End of a one-shot overrides a coincident CTRL write
      if (doStop) en <= 1'b0;
      if (presetWr)
        preset <= (preset & ~wrMask[CNT_W-1:0]) | (din[CNT_W-1:0] & wrMask[CNT_W-1:0]);
      if (doLoad)
        count <= (preset == '0) ? CNT_W'(1) : preset;
      else if (doDec)
        count <= count - CNT_W'(1);
      else if (doInt)
        count <= '0;
      if (statusClr) pending <= 1'b0;
      if (doInt)     pending <= 1'b1;
    end
  end

  always_comb begin
    ctrlWord                     = '0;
    ctrlWord[CTRL_EN]            = en;
    ctrlWord[CTRL_MODE_LO +: 2]  = mode;
    ctrlWord[CTRL_IM]            = im;
    ctrlWord[CTRL_PS_LO +: 4]    = ps;
    case (regSel)
      REG_CTRL:   rdData = ctrlWord;
      REG_PRESET: rdData = 32'(preset);
      REG_COUNT:  rdData = 32'(count);
      default:    rdData = {31'b0, pending};
    endcase
  end

  assign intReq = pending & im;

endmodule

// File: rtl/timer_bank.sv
// NUM_CH independent down-counter timers behind a word-addressed register bus; reads combinational, writes land next cycle, no stalls.
// Prescaler support is enabled by defining TIMER_BANK_PRESCALE_EN.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        Addr,
  input  logic [31:0]       Din,
  input  logic [3:0]        BE,
  input  logic              We,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IntReq
);

  logic [2:0]        chIdx;
  logic [1:0]        regSel;
  logic [NUM_CH-1:0] chWe;
  logic [31:0]       chRd [NUM_CH];

  assign chIdx  = Addr[4:2];
  assign regSel = Addr[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    assign chWe[i] = We && (chIdx == 3'(i));
    timer_channel #(.CNT_W(CNT_W)) uCh (
      .clk    (clk),
      .reset  (reset),
      .we     (chWe[i]),
      .regSel (regSel),
      .din    (Din),
      .be     (BE),
      .rdData (chRd[i]),
      .intReq (IntReq[i])
    );
  end

  // Channel indices with no instance fall through to zero
  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (chIdx == 3'(i)) Dout = chRd[i];
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank (default build, NUM_CH=2, CNT_W=32).
module tb_timer_bank;
  import timer_bank_pkg::*;

  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        Addr;
  logic [31:0]       Din;
  logic [3:0]        BE;
  logic              We;
  logic [31:0]       Dout;
  logic [NUM_CH-1:0] IntReq;

  timer_bank #(.NUM_CH(NUM_CH), .CNT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .Din    (Din),
    .BE     (BE),
    .We     (We),
    .Dout   (Dout),
    .IntReq (IntReq)
  );

  always #50 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  string       tagQ [$];
  logic [31:0] expQ [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic popCheck(logic [31:0] got);
    if (expQ.size() == 0) begin
      nChecks++;
      $display("FAIL scoreboard_empty: got 0x%08h, expected an entry", got);
    end else begin
      check(tagQ.pop_front(), got, expQ.pop_front());
    end
  endtask

  task automatic rdExp(string tag, logic [4:0] a, logic [31:0] e);
    tagQ.push_back(tag);
    expQ.push_back(e);
    Addr = a;
    #1;
    popCheck(Dout);
  endtask

  task automatic irqExp(string tag, logic [NUM_CH-1:0] e);
    tagQ.push_back(tag);
    expQ.push_back(32'(e));
    #1;
    popCheck(32'(IntReq));
  endtask

  function automatic logic [4:0] ra(input int ch, input logic [1:0] r);
    return {3'(ch), r};
  endfunction

  // Caller sits just after a negedge; returns just after the negedge following the write edge
  task automatic wr(logic [4:0] a, logic [31:0] d, logic [3:0] b);
    Addr = a;
    Din  = d;
    BE   = b;
    We   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    We   = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkAllZero(string tag);
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < 4; r++)
        rdExp($sformatf("%s_ch%0d_r%0d", tag, ch, r), ra(ch, 2'(r)), 32'h0);
    irqExp({tag, "_irq"}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    We    = 1'b0;
    Addr  = '0;
    Din   = '0;
    BE    = '0;
    cyc(3);
    reset = 1'b0;
    checkAllZero("rst");

    // One-shot ch0, PRESET=5: interrupt after e7, EN cleared after e8
    wr(ra(0, REG_PRESET), 32'd5, 4'hF);
    wr(ra(0, REG_CTRL), 32'h9, 4'hF);
    cyc(6);
    irqExp("os_before", 2'b00);
    cyc(1);
    irqExp("os_irq", 2'b01);
    rdExp("os_count0", ra(0, REG_COUNT), 32'h0);
    rdExp("os_ctrl_e7", ra(0, REG_CTRL), 32'h9);
    cyc(1);
    rdExp("os_ctrl_e8", ra(0, REG_CTRL), 32'h8);
    rdExp("os_status", ra(0, REG_STATUS), 32'h1);
    wr(ra(0, REG_STATUS), 32'h1, 4'h1);
    irqExp("os_w1c", 2'b00);
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      irqExp("os_quiet", 2'b00);
    end

    // Auto-reload ch1, PRESET=3: period 5
    wr(ra(1, REG_PRESET), 32'd3, 4'hF);
    wr(ra(1, REG_CTRL), 32'hB, 4'hF);
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      irqExp("ar_low", 2'b00);
      cyc(1);
      irqExp("ar_rise", 2'b10);
      wr(ra(1, REG_STATUS), 32'h1, 4'h1);
      irqExp("ar_clr", 2'b00);
      cyc(3);
    end
    wr(ra(1, REG_CTRL), 32'h0, 4'hF);
    cyc(3);
    wr(ra(1, REG_STATUS), 32'h1, 4'h1);
    rdExp("ar_stop_status", ra(1, REG_STATUS), 32'h0);
    irqExp("ar_stop_irq", 2'b00);

    // Pause at COUNT=10, hold 20 cycles, resume: interrupt 10 cycles later
    wr(ra(0, REG_PRESET), 32'd20, 4'hF);
    wr(ra(0, REG_CTRL), 32'h9, 4'hF);
    cyc(11);
    rdExp("pr_count11", ra(0, REG_COUNT), 32'd11);
    wr(ra(0, REG_CTRL), 32'h8, 4'hF);
    rdExp("pr_count10", ra(0, REG_COUNT), 32'd10);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      rdExp("pr_hold", ra(0, REG_COUNT), 32'd10);
    end
    wr(ra(0, REG_CTRL), 32'h9, 4'hF);
    cyc(9);
    irqExp("pr_before", 2'b00);
    cyc(1);
    irqExp("pr_irq", 2'b01);
    wr(ra(0, REG_STATUS), 32'h1, 4'h1);
    irqExp("pr_clr", 2'b00);

    // W1C in the same edge as the INT entry, with IM=0
    wr(ra(0, REG_PRESET), 32'd4, 4'hF);
    wr(ra(0, REG_CTRL), 32'h1, 4'hF);
    cyc(5);
    rdExp("sim_count1", ra(0, REG_COUNT), 32'd1);
    wr(ra(0, REG_STATUS), 32'h1, 4'h1);
    rdExp("sim_pending", ra(0, REG_STATUS), 32'h1);
    irqExp("sim_masked", 2'b00);
    wr(ra(0, REG_CTRL), 32'h8, 4'hF);
    irqExp("sim_unmasked", 2'b01);
    rdExp("sim_ctrl", ra(0, REG_CTRL), 32'h8);
    wr(ra(0, REG_STATUS), 32'h1, 4'h1);
    irqExp("sim_clr", 2'b00);

    // Decode: channel 5 absent; byte enables; COUNT read-only
    rdExp("dec_ch5_ctrl", ra(5, REG_CTRL), 32'h0);
    wr(ra(5, REG_PRESET), 32'hDEADBEEF, 4'hF);
    wr(ra(5, REG_CTRL), 32'hF, 4'hF);
    rdExp("dec_ch5_preset", ra(5, REG_PRESET), 32'h0);
    rdExp("dec_ch0_preset", ra(0, REG_PRESET), 32'd4);
    rdExp("dec_ch1_preset", ra(1, REG_PRESET), 32'd3);
    rdExp("dec_ch0_ctrl", ra(0, REG_CTRL), 32'h8);
    rdExp("dec_ch1_ctrl", ra(1, REG_CTRL), 32'h0);
    cyc(5);
    irqExp("dec_irq", 2'b00);
    wr(ra(0, REG_PRESET), 32'h0, 4'hF);
    wr(ra(0, REG_PRESET), 32'hFFFFFFFF, 4'h1);
    rdExp("be_byte0", ra(0, REG_PRESET), 32'h000000FF);
    wr(ra(0, REG_PRESET), 32'h12345678, 4'h4);
    rdExp("be_byte2", ra(0, REG_PRESET), 32'h003400FF);
    wr(ra(0, REG_COUNT), 32'hABC, 4'hF);
    rdExp("count_ro", ra(0, REG_COUNT), 32'h0);

    // Reset with COUNT=2 mid-count
    wr(ra(0, REG_PRESET), 32'd6, 4'hF);
    wr(ra(0, REG_CTRL), 32'h9, 4'hF);
    cyc(6);
    rdExp("rm_count2", ra(0, REG_COUNT), 32'd2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checkAllZero("rm");
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      irqExp("rm_quiet", 2'b00);
    end
    rdExp("rm_count_idle", ra(0, REG_COUNT), 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
